// File: rtl/term_net_pkg.sv
// Shared types, defaults and the term-to-net bit mapping for the term_net bridge.
package term_net_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_REVERSE  = 0;
    localparam int DEF_COUNT_W  = 16;
    // Upper bound on channel width accepted by bit_map.
    localparam int MAX_WIDTH    = 1024;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    // Maps the low `width` bits of data; rev=1 makes net bit i = term bit width-1-i.
    function automatic logic [MAX_WIDTH-1:0] bit_map(
        input logic [MAX_WIDTH-1:0] data,
        input logic                 rev,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] flipped;
        flipped = {<<{data}};
        if (rev) begin
            bit_map = flipped >> (MAX_WIDTH - width);
        end else begin
            bit_map = data;
        end
    endfunction

endpackage

// File: rtl/term_net_skid.sv
// One bridge channel: 2-entry valid/ready skid buffer with bit mapping at accept
// and a wrapping count of completed output transfers.
module term_net_skid
    import term_net_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rev,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count
);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   main_reg;
    logic [WIDTH-1:0]   skid_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [WIDTH-1:0]   mapped;
    logic               accept;
    logic               xfer;

    assign mapped = WIDTH'(bit_map(MAX_WIDTH'(in_data), rev, WIDTH));
    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) state_next = FULL1;
            end
            FULL1: begin
                if (accept && !xfer)      state_next = FULL2;
                else if (!accept && xfer) state_next = EMPTY;
            end
            FULL2: begin
                if (xfer) state_next = FULL1;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake flags depend only on the state register, so in_ready never
    // follows out_ready combinationally.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_reg)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            FULL1: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            FULL2: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg  <= '0;
            skid_reg  <= '0;
            count_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) main_reg <= mapped;
                end
                FULL1: begin
                    if (accept && xfer) main_reg <= mapped;
                    else if (accept)    skid_reg <= mapped;
                end
                FULL2: begin
                    if (xfer) main_reg <= skid_reg;
                end
                default: ;
            endcase
            if (xfer) count_reg <= count_reg + COUNT_W'(1);
        end
    end

    assign out_data  = main_reg;
    assign out_count = count_reg;

endmodule

// File: rtl/term_net_bridge.sv
// Registered term-to-net bridge: CHANNELS independent skid-buffered buses with
// per-channel bit-order mapping and transfer counters.
module term_net_bridge
    import term_net_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int REVERSE  = DEF_REVERSE,
    parameter int COUNT_W  = DEF_COUNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         cfg_reverse,
    output logic [CHANNELS-1:0]         out_valid,
    input  logic [CHANNELS-1:0]         out_ready,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic [CHANNELS*COUNT_W-1:0] out_count
);

    localparam logic REV_DEFAULT = (REVERSE != 0);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            term_net_skid #(
                .WIDTH   (WIDTH),
                .COUNT_W (COUNT_W)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .rev       (cfg_reverse[gi] ^ REV_DEFAULT),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_data   (in_data[gi*WIDTH +: WIDTH]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_data  (out_data[gi*WIDTH +: WIDTH]),
                .out_count (out_count[gi*COUNT_W +: COUNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_term_net_bridge.sv
// Scoreboard bench for term_net_bridge: a queue model per channel predicts
// handshakes, data order, mapping and counter values.
module tb_term_net_bridge;

    localparam int W  = 32;
    localparam int CH = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [CH*W-1:0]   in_data;
    logic [CH-1:0]     cfg_reverse;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready;
    logic [CH*W-1:0]   out_data;
    logic [CH*CW-1:0]  out_count;

    always #5 clk = ~clk;

    term_net_bridge #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .REVERSE  (0),
        .COUNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .cfg_reverse (cfg_reverse),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [W-1:0] exp_q[CH][$];
    int          exp_cnt[CH];
    logic [W-1:0] src_q[CH][$];
    int          rdy_mode[CH];
    bit          rnd_valid;
    bit          rnd_cfg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_map(input logic [W-1:0] d, input logic r);
        logic [W-1:0] res;
        for (int i = 0; i < W; i++) res[i] = r ? d[W-1-i] : d[i];
        return res;
    endfunction

    // Monitor: samples one time unit before each rising edge.
    initial begin
        int sz;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                for (int c = 0; c < CH; c++) begin
                    exp_q[c].delete();
                    exp_cnt[c] = 0;
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    sz = exp_q[c].size();
                    check($sformatf("ch%0d in_ready", c), 64'(in_ready[c]), 64'(sz < 2));
                    check($sformatf("ch%0d out_valid", c), 64'(out_valid[c]), 64'(sz > 0));
                    check($sformatf("ch%0d out_count", c), 64'(out_count[c*CW +: CW]),
                          64'(exp_cnt[c] % (1 << CW)));
                    if (sz > 0)
                        check($sformatf("ch%0d out_data", c), 64'(out_data[c*W +: W]), 64'(exp_q[c][0]));
                    if (out_valid[c] && out_ready[c] && sz > 0) begin
                        $display("ch%0d xfer data=%08h count=%0d", c, out_data[c*W +: W], exp_cnt[c] + 1);
                        void'(exp_q[c].pop_front());
                        exp_cnt[c]++;
                    end
                    if (in_valid[c] && in_ready[c])
                        exp_q[c].push_back(ref_map(in_data[c*W +: W], cfg_reverse[c]));
                end
            end
        end
    end

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                in_valid[c] = (src_q[c].size() > 0) && (!rnd_valid || $urandom_range(3) != 0);
                in_data[c*W +: W] = in_valid[c] ? src_q[c][0] : W'($urandom());
                out_ready[c] = (rdy_mode[c] == 0) ? 1'b0 :
                               (rdy_mode[c] == 1) ? 1'b1 : 1'($urandom_range(1));
                if (rnd_cfg) cfg_reverse[c] = 1'($urandom_range(1));
            end
            #4;
            for (int c = 0; c < CH; c++)
                if (in_valid[c] && in_ready[c]) void'(src_q[c].pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_valid = '0;
        rst_n    = 1'b0;
        for (int c = 0; c < CH; c++) src_q[c].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_rand(input int c, input int n);
        for (int i = 0; i < n; i++) src_q[c].push_back(W'($urandom()));
    endtask

    initial begin
        logic [W-1:0] wa;
        in_valid = '0;
        in_data = '0;
        out_ready = '0;
        cfg_reverse = '0;
        rnd_valid = 0;
        rnd_cfg = 0;
        for (int c = 0; c < CH; c++) rdy_mode[c] = 1;

        do_reset();
        check("reset in_ready", 64'(in_ready), 64'(2'b11));
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_count", 64'(out_count), 64'd0);
        check("reset out_data", out_data, 64'd0);

        // Straight then reversed mapping on channel 0.
        src_q[0].push_back(32'h0000_0001);
        run_cycles(1);
        check("map straight valid", 64'(out_valid[0]), 64'd1);
        check("map straight data", 64'(out_data[W-1:0]), 64'h0000_0001);
        cfg_reverse[0] = 1'b1;
        src_q[0].push_back(32'h0000_0001);
        run_cycles(1);
        check("map reversed data", 64'(out_data[W-1:0]), 64'h8000_0000);
        cfg_reverse[0] = 1'b0;
        run_cycles(2);

        // Back-pressure: A and B buffered, C held by the source.
        do_reset();
        rdy_mode[0] = 0;
        wa = W'($urandom());
        src_q[0].push_back(wa);
        push_rand(0, 2);
        run_cycles(4);
        check("bp in_ready low", 64'(in_ready[0]), 64'd0);
        check("bp C held", 64'(src_q[0].size()), 64'd1);
        check("bp head is A", 64'(out_data[W-1:0]), 64'(wa));
        rdy_mode[0] = 1;
        run_cycles(3);
        check("bp count", 64'(out_count[CW-1:0]), 64'd3);
        check("bp drained", 64'(out_valid[0]), 64'd0);

        // Full-rate stream of 100 words.
        do_reset();
        push_rand(0, 100);
        run_cycles(100);
        check("stream no bubbles", 64'(src_q[0].size()), 64'd0);
        run_cycles(1);
        check("stream count", 64'(out_count[CW-1:0]), 64'(100 % (1 << CW)));

        // Counter wrap.
        do_reset();
        push_rand(0, 17);
        run_cycles(18);
        check("wrap count", 64'(out_count[CW-1:0]), 64'd1);

        // Channel 0 stalled in FULL2 while channel 1 streams.
        do_reset();
        rdy_mode[0] = 0;
        rdy_mode[1] = 1;
        push_rand(0, 3);
        push_rand(1, 20);
        run_cycles(21);
        check("indep ch1 streamed", 64'(src_q[1].size()), 64'd0);
        check("indep ch1 count", 64'(out_count[2*CW-1:CW]), 64'(20 % (1 << CW)));
        check("indep ch0 stalled", 64'(in_ready[0]), 64'd0);
        check("indep ch0 held", 64'(src_q[0].size()), 64'd1);

        // Randomized traffic.
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        rnd_valid = 1;
        rnd_cfg = 1;
        push_rand(0, 150);
        push_rand(1, 150);
        run_cycles(300);

        // Asynchronous reset mid-stream.
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", 64'(in_ready), 64'(2'b11));
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst out_count", 64'(out_count), 64'd0);
        check("async rst out_data", out_data, 64'd0);
        do_reset();

        push_rand(0, 60);
        push_rand(1, 60);
        run_cycles(150);
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        rnd_valid = 0;
        for (int k = 0; k < 200; k++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && out_valid == '0) break;
            run_cycles(1);
        end
        check("final drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
